// File: rtl/guess_pkg.sv
// Shared state and hint encodings for the number-guessing engine.
package guess_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        HINT_NONE   = 2'd0,
        HINT_HIGHER = 2'd1,
        HINT_LOWER  = 2'd2,
        HINT_EQUAL  = 2'd3
    } hint_t;

    // HIGHER means the secret lies above the guess.
    function automatic hint_t rel_hint(input logic secret_gt, input logic secret_eq);
        hint_t h;
        if (secret_eq) begin
            h = HINT_EQUAL;
        end else if (secret_gt) begin
            h = HINT_HIGHER;
        end else begin
            h = HINT_LOWER;
        end
        return h;
    endfunction

endpackage

// File: rtl/guess_game_core_bcd.sv
// Saturating BCD up-counter with synchronous clear; digit 0 in the low nibble.
module bcd_sat_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   bcd
);

    logic [4*DIGITS-1:0] cnt_q;
    logic [4*DIGITS-1:0] cnt_d;
    logic                carry_s;
    logic                all9_s;

    // Next count: clear dominates, increment ripples a carry through the digits.
    always_comb begin
        cnt_d   = cnt_q;
        carry_s = 1'b1;
        all9_s  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            all9_s = all9_s & (cnt_q[4*i +: 4] == 4'd9);
        end
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !all9_s) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry_s && (cnt_q[4*i +: 4] == 4'd9)) begin
                    cnt_d[4*i +: 4] = 4'd0;
                    carry_s         = 1'b1;
                end else begin
                    cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + {3'd0, carry_s};
                    carry_s         = 1'b0;
                end
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bcd = cnt_q;

endmodule

// File: rtl/guess_game_core.sv
// Number-guessing engine: secret latch, higher/lower scoring, try limit and BCD win score.
module guess_game_core
    import guess_pkg::*;
#(
    parameter int NUM_W        = 4,
    parameter int MAX_TRIES    = 5,
    parameter int SCORE_DIGITS = 2,
    parameter bit CLR_ON_LOSE  = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_key,
    input  logic                           guess_key,
    input  logic                           score_clr,
    input  logic [NUM_W-1:0]               secret,
    input  logic [NUM_W-1:0]               guess,
    output logic [1:0]                     state,
    output logic [1:0]                     hint,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
    output logic [4*SCORE_DIGITS-1:0]      score_bcd,
    output logic                           round_done
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] TRIES_FULL = TW'(MAX_TRIES);

    game_state_t      state_q, state_d;
    hint_t            hint_q, hint_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic [NUM_W-1:0] secret_q, secret_d;
    logic             round_done_q, round_done_d;
    logic             load_key_q, guess_key_q;
    logic             load_ev_s, guess_ev_s;
    logic             score_inc_s, lose_clr_s;

    assign load_ev_s  = load_key & ~load_key_q;
    assign guess_ev_s = guess_key & ~guess_key_q;

    // Next-state logic; a load event always wins over a guess in the same cycle.
    always_comb begin
        state_d      = state_q;
        hint_d       = hint_q;
        tries_d      = tries_q;
        secret_d     = secret_q;
        round_done_d = 1'b0;
        score_inc_s  = 1'b0;
        lose_clr_s   = 1'b0;
        if (load_ev_s) begin
            secret_d = secret;
            tries_d  = TRIES_FULL;
            hint_d   = HINT_NONE;
            state_d  = ST_PLAY;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (guess_ev_s && (tries_q != '0)) begin
                        hint_d = rel_hint(secret_q > guess, secret_q == guess);
                        if (secret_q == guess) begin
                            state_d      = ST_WIN;
                            score_inc_s  = 1'b1;
                            round_done_d = 1'b1;
                        end else begin
                            tries_d = tries_q - TW'(1);
                            if (tries_q == TW'(1)) begin
                                state_d      = ST_LOSE;
                                round_done_d = 1'b1;
                                lose_clr_s   = CLR_ON_LOSE;
                            end else begin
                                state_d = ST_PLAY;
                            end
                        end
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Game state registers; key history resets high so a key held through reset is not an event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hint_q       <= HINT_NONE;
            tries_q      <= TRIES_FULL;
            secret_q     <= '0;
            round_done_q <= 1'b0;
            load_key_q   <= 1'b1;
            guess_key_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            hint_q       <= hint_d;
            tries_q      <= tries_d;
            secret_q     <= secret_d;
            round_done_q <= round_done_d;
            load_key_q   <= load_key;
            guess_key_q  <= guess_key;
        end
    end

    bcd_sat_counter #(
        .DIGITS (SCORE_DIGITS)
    ) u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr | lose_clr_s),
        .inc   (score_inc_s),
        .bcd   (score_bcd)
    );

    assign state      = state_q;
    assign hint       = hint_q;
    assign tries_left = tries_q;
    assign round_done = round_done_q;

endmodule

// File: tb/tb_guess_game_core.sv
// Directed bench for guess_game_core: two instances (2-digit and 1-digit score) share the stimulus.
module tb_guess_game_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_key;
    logic       guess_key;
    logic       score_clr;
    logic [3:0] secret;
    logic [3:0] guess;

    logic [1:0] state_a, hint_a, state_b, hint_b;
    logic [2:0] tries_a, tries_b;
    logic [7:0] score_a;
    logic [3:0] score_b;
    logic       done_a, done_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    guess_game_core u_dut (
        .clk(clk), .reset(reset), .load_key(load_key), .guess_key(guess_key),
        .score_clr(score_clr), .secret(secret), .guess(guess),
        .state(state_a), .hint(hint_a), .tries_left(tries_a), .score_bcd(score_a),
        .round_done(done_a)
    );

    guess_game_core #(.SCORE_DIGITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .load_key(load_key), .guess_key(guess_key),
        .score_clr(score_clr), .secret(secret), .guess(guess),
        .state(state_b), .hint(hint_b), .tries_left(tries_b), .score_bcd(score_b),
        .round_done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; load_key = 1'b0; guess_key = 1'b0; score_clr = 1'b0;
        secret = 4'd0; guess = 4'd0;
        tick(); tick();
        chk("rst_state", state_a, 0); chk("rst_hint", hint_a, 0);
        chk("rst_tries", tries_a, 5); chk("rst_score", score_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_state_b", state_b, 0); chk("rst_hint_b", hint_b, 0);
        chk("rst_tries_b", tries_b, 5); chk("rst_score_b", score_b, 0);
        chk("rst_done_b", done_b, 0);
        reset = 1'b0; tick();

        // Guess in IDLE is ignored
        guess = 4'd3; guess_key = 1'b1; tick();
        chk("idle_guess_state", state_a, 0); chk("idle_guess_tries", tries_a, 5);
        guess_key = 1'b0; tick();

        // Test 1: load secret 9
        secret = 4'd9; load_key = 1'b1; tick();
        chk("t1_state", state_a, 1); chk("t1_tries", tries_a, 5);
        chk("t1_hint", hint_a, 0); chk("t1_score", score_a, 0);
        load_key = 1'b0; tick();

        // Test 2: guesses 3, 12, 9
        guess = 4'd3; guess_key = 1'b1; tick();
        chk("t2_g3_hint", hint_a, 1); chk("t2_g3_tries", tries_a, 4);
        guess_key = 1'b0; tick();
        guess = 4'd12; guess_key = 1'b1; tick();
        chk("t2_g12_hint", hint_a, 2); chk("t2_g12_tries", tries_a, 3);
        guess_key = 1'b0; tick();
        guess = 4'd9; guess_key = 1'b1; tick();
        chk("t2_win_hint", hint_a, 3); chk("t2_win_tries", tries_a, 3);
        chk("t2_win_state", state_a, 2); chk("t2_win_done", done_a, 1);
        chk("t2_win_score", score_a, 8'h01);
        guess_key = 1'b0; tick();
        chk("t2_done_pulse", done_a, 0); chk("t2_hold_state", state_a, 2);

        // Test 3: secret 7, five wrong guesses of 0
        secret = 4'd7; load_key = 1'b1; tick();
        chk("t3_state", state_a, 1); chk("t3_tries", tries_a, 5);
        load_key = 1'b0; tick();
        for (int i = 1; i <= 5; i++) begin
            guess = 4'd0; guess_key = 1'b1; tick();
            chk("t3_tries_n", tries_a, 5 - i); chk("t3_hint_n", hint_a, 1);
            chk("t3_state_n", state_a, (i == 5) ? 3 : 1);
            chk("t3_done_n", done_a, (i == 5) ? 1 : 0);
            guess_key = 1'b0; tick();
        end
        chk("t3_lose_score", score_a, 0); chk("t3_done_clr", done_a, 0);
        guess_key = 1'b1; tick();
        chk("t3_6th_state", state_a, 3); chk("t3_6th_tries", tries_a, 0);
        chk("t3_6th_done", done_a, 0);
        guess_key = 1'b0; tick();

        // Test 4: ten wins; 1-digit score saturates at 9, 2-digit ripples to 10
        for (int k = 1; k <= 10; k++) begin
            secret = 4'd2; load_key = 1'b1; tick();
            load_key = 1'b0; tick();
            guess = 4'd2; guess_key = 1'b1; tick();
            chk("t4_state", state_a, 2);
            chk("t4_score2", score_a, ((k / 10) << 4) | (k % 10));
            chk("t4_score1", score_b, (k > 9) ? 9 : k);
            guess_key = 1'b0; tick();
        end
        secret = 4'd6; load_key = 1'b1; tick();
        load_key = 1'b0; tick();
        guess = 4'd6; guess_key = 1'b1; score_clr = 1'b1; tick();
        chk("t4_clrwin_state", state_a, 2); chk("t4_clrwin_score2", score_a, 0);
        chk("t4_clrwin_score1", score_b, 0);
        guess_key = 1'b0; score_clr = 1'b0; tick();

        // Test 5: simultaneous load+guess, then a held guess key
        secret = 4'd5; load_key = 1'b1; tick();
        load_key = 1'b0; tick();
        guess = 4'd1; guess_key = 1'b1; tick();
        chk("t5_pre_tries", tries_a, 4);
        guess_key = 1'b0; tick();
        secret = 4'd11; guess = 4'd11; load_key = 1'b1; guess_key = 1'b1; tick();
        chk("t5_sim_state", state_a, 1); chk("t5_sim_tries", tries_a, 5);
        chk("t5_sim_hint", hint_a, 0); chk("t5_sim_done", done_a, 0);
        load_key = 1'b0; guess_key = 1'b0; tick();
        guess = 4'd0; guess_key = 1'b1;
        repeat (20) tick();
        chk("t5_held_tries", tries_a, 4); chk("t5_held_hint", hint_a, 1);
        chk("t5_held_state", state_a, 1);
        guess_key = 1'b0; tick();
        guess = 4'd11; guess_key = 1'b1; tick();
        chk("t5_newsecret_win", state_a, 2); chk("t5_score", score_a, 8'h01);
        guess_key = 1'b0; tick();

        // Test 6: reset mid-PLAY with tries=2, keys held through reset release
        secret = 4'd8; load_key = 1'b1; tick();
        load_key = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin
            guess = 4'd0; guess_key = 1'b1; tick();
            guess_key = 1'b0; tick();
        end
        chk("t6_pre_tries", tries_a, 2); chk("t6_pre_state", state_a, 1);
        reset = 1'b1; load_key = 1'b1; guess_key = 1'b1; tick();
        chk("t6_rst_state", state_a, 0); chk("t6_rst_tries", tries_a, 5);
        chk("t6_rst_score", score_a, 0); chk("t6_rst_hint", hint_a, 0);
        reset = 1'b0; tick();
        chk("t6_held_state", state_a, 0);
        tick();
        chk("t6_held_state2", state_a, 0);
        load_key = 1'b0; guess_key = 1'b0; tick();
        secret = 4'd4; load_key = 1'b1; tick();
        chk("t6_reload_state", state_a, 1); chk("t6_reload_tries", tries_a, 5);
        load_key = 1'b0; tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
